// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes and the
// next-state function used by the TAP FSM.
package jtag_pkg;

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_t;

    localparam logic [3:0] OP_EXTEST         = 4'b0000;
    localparam logic [3:0] OP_IDCODE         = 4'b0001;
    localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'b0010;
    localparam logic [3:0] OP_INTEST         = 4'b0011;
    localparam logic [3:0] OP_BYPASS         = 4'b1111;

    // Fixed pattern captured into the IR shift register; the 01 LSBs let a
    // host find the IR boundaries in a multi-device chain.
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        unique case (s)
            TLR:      n = tms ? TLR    : RTI;
            RTI:      n = tms ? SEL_DR : RTI;
            SEL_DR:   n = tms ? SEL_IR : CAP_DR;
            SEL_IR:   n = tms ? TLR    : CAP_IR;
            CAP_DR:   n = tms ? EX1_DR : SH_DR;
            SH_DR:    n = tms ? EX1_DR : SH_DR;
            EX1_DR:   n = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: n = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   n = tms ? UPD_DR : SH_DR;
            UPD_DR:   n = tms ? SEL_DR : RTI;
            CAP_IR:   n = tms ? EX1_IR : SH_IR;
            SH_IR:    n = tms ? EX1_IR : SH_IR;
            EX1_IR:   n = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: n = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   n = tms ? UPD_IR : SH_IR;
            UPD_IR:   n = tms ? SEL_DR : RTI;
            default:  n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP state machine with decode strobes for the current state and
// the few next-state decodes the registered outputs need.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_t state,
    output logic       cap_dr,
    output logic       sh_dr,
    output logic       upd_dr,
    output logic       cap_ir,
    output logic       sh_ir,
    output logic       upd_ir,
    output logic       nx_sh_dr,
    output logic       nx_sh_ir,
    output logic       nx_tlr
);

    tap_state_t next_state;

    assign next_state = tap_next(state, tms);

    always_ff @(posedge tck) begin
        if (trst) state <= TLR;
        else      state <= next_state;
    end

    assign cap_dr   = (state == CAP_DR);
    assign sh_dr    = (state == SH_DR);
    assign upd_dr   = (state == UPD_DR);
    assign cap_ir   = (state == CAP_IR);
    assign sh_ir    = (state == SH_IR);
    assign upd_ir   = (state == UPD_IR);
    // Next-state decodes ignore trst; the controller gives trst priority.
    assign nx_sh_dr = (next_state == SH_DR);
    assign nx_sh_ir = (next_state == SH_IR);
    assign nx_tlr   = (next_state == TLR);

endmodule

// File: rtl/tap_controller.sv
// TAP front end: FSM, instruction register, BYPASS/IDCODE data registers,
// boundary-scan chain strobes and the registered TDO mux.
module tap_controller
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    output logic       bsr_tdi,
    input  logic       bsr_tdo,
    output logic       bsr_capture,
    output logic       bsr_shift,
    output logic       bsr_update,
    output logic       bsr_mode,
    output logic [3:0] tap_state
);

    localparam logic [IR_WIDTH-1:0] IR_EXTEST = IR_WIDTH'(OP_EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(OP_SAMPLE_PRELOAD);
    localparam logic [IR_WIDTH-1:0] IR_INTEST = IR_WIDTH'(OP_INTEST);
    localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE);

    tap_state_t state;
    logic cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;
    logic nx_sh_dr, nx_sh_ir, nx_tlr;

    tap_fsm u_fsm (
        .tck      (tck),
        .trst     (trst),
        .tms      (tms),
        .state    (state),
        .cap_dr   (cap_dr),
        .sh_dr    (sh_dr),
        .upd_dr   (upd_dr),
        .cap_ir   (cap_ir),
        .sh_ir    (sh_ir),
        .upd_ir   (upd_ir),
        .nx_sh_dr (nx_sh_dr),
        .nx_sh_ir (nx_sh_ir),
        .nx_tlr   (nx_tlr)
    );

    logic [IR_WIDTH-1:0] ir, ir_sr, ir_sr_d;
    logic [31:0]         id_sr, id_sr_d;
    logic                byp, byp_d;
    logic                tdo_d;
    logic                sel_bsr, sel_id, sel_byp;

    // Any opcode that is not a chain or IDCODE instruction falls back to BYPASS.
    assign sel_bsr = (ir == IR_EXTEST) || (ir == IR_SAMPLE) || (ir == IR_INTEST);
    assign sel_id  = (ir == IR_IDCODE);
    assign sel_byp = !sel_bsr && !sel_id;

    always_comb begin
        ir_sr_d = ir_sr;
        id_sr_d = id_sr;
        byp_d   = byp;
        if (cap_ir)     ir_sr_d = IR_CAP;
        else if (sh_ir) ir_sr_d = {tdi, ir_sr[IR_WIDTH-1:1]};
        if (cap_dr) begin
            if (sel_id)  id_sr_d = IDCODE_VALUE;
            if (sel_byp) byp_d   = 1'b0;
        end else if (sh_dr) begin
            if (sel_id)  id_sr_d = {tdi, id_sr[31:1]};
            if (sel_byp) byp_d   = tdi;
        end
        // TDO presents the bit that will sit at the register LSB after this
        // edge, so bit k is visible for the whole k-th Shift cycle.
        tdo_d = 1'b0;
        if (nx_sh_ir)      tdo_d = ir_sr_d[0];
        else if (nx_sh_dr) begin
            if (sel_bsr)     tdo_d = bsr_tdo;
            else if (sel_id) tdo_d = id_sr_d[0];
            else             tdo_d = byp_d;
        end
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            ir     <= IR_IDCODE;
            ir_sr  <= IR_CAP;
            id_sr  <= IDCODE_VALUE;
            byp    <= 1'b0;
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            ir_sr  <= ir_sr_d;
            id_sr  <= id_sr_d;
            byp    <= byp_d;
            if (nx_tlr)      ir <= IR_IDCODE;
            else if (upd_ir) ir <= ir_sr;
            tdo    <= tdo_d;
            tdo_en <= nx_sh_dr || nx_sh_ir;
        end
    end

    assign bsr_tdi     = tdi;
    assign bsr_capture = cap_dr && sel_bsr;
    assign bsr_shift   = sh_dr  && sel_bsr;
    assign bsr_update  = upd_dr && sel_bsr;
    assign bsr_mode    = (ir == IR_EXTEST) || (ir == IR_INTEST);
    assign tap_state   = state;

endmodule
